// File: rtl/vga_fb_pkg.sv
// Shared widths, frame size and arbiter state for the
// VGA frame-buffer arbiter slice.
package vga_fb_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 24;
  localparam int FRAME_PIXELS = 307200;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } arb_state_e;

endpackage

// File: rtl/vga_fb_if.sv
// Writer request port and single-port SRAM bus used by
// the frame-buffer arbiter.
interface vga_fb_wr_if
  import vga_fb_pkg::*;
();
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid, addr, data,
    input  ready
  );
  modport slave (
    input  valid, addr, data,
    output ready
  );
endinterface

interface vga_fb_sram_if
  import vga_fb_pkg::*;
();
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr, we, wdata,
    input  rdata
  );
  modport slave (
    input  addr, we, wdata,
    output rdata
  );
endinterface

// File: rtl/vga_fb_fifo.sv
// Scan-out prefetch FIFO: push/pop/flush with occupancy.
// Flush wins over push and pop; pop on empty is ignored.
module vga_fb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + (PW+1)'(1);
        (w_pop && !w_push): r_count <= r_count - (PW+1)'(1);
        default:            r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one frame-buffer SRAM between VGA scan-out
// prefetch reads and a pixel writer.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FRAME_PIXELS = vga_fb_pkg::FRAME_PIXELS,
  parameter int FIFO_DEPTH   = 8,
  parameter int LOW_WM       = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_pix_req,
  output logic [DATA_W-1:0] o_pix,
  output logic              o_underflow,
  vga_fb_wr_if.slave        wr,
  vga_fb_sram_if.master     sram
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     LP_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     LP_LOW   = CW'(LOW_WM);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(FRAME_PIXELS);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_underflow;
  logic [DATA_W-1:0] r_pix;

  logic [CW-1:0]     w_occ;
  logic [CW-1:0]     w_level;
  logic [CW-1:0]     w_space;
  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_more;
  logic              w_rd;
  logic              w_rdy;
  logic              w_wr_go;

  assign w_level = w_occ + CW'(r_inflight);
  assign w_space = LP_DEPTH - w_level;
  assign w_more  = (r_rd_addr < LP_LAST);

  vga_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_frame_start),
    .i_push  (r_inflight),
    .i_wdata (sram.rdata),
    .i_pop   (i_pix_req),
    .o_rdata (w_head),
    .o_count (w_occ),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_rdy  = 1'b0;
    unique case (r_state)
      IDLE: w_rdy = 1'b1;
      FILL: begin
        if (w_level == LP_DEPTH || !w_more) w_next = RUN;
        else                                w_rd   = 1'b1;
      end
      RUN: begin
        if (w_level < LP_LOW && w_more) begin
          w_rd = 1'b1;
        end else begin
          w_rdy = 1'b1;
          if (!wr.valid && w_space != '0 && w_more)
            w_rd = 1'b1;
        end
        if (!w_more && w_empty && !r_inflight)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // A restart drops any read that would land in the flushed FIFO
    if (i_frame_start) begin
      w_next = FILL;
      w_rd   = 1'b0;
    end
  end

  assign w_wr_go    = i_rst_n && w_rdy && wr.valid;
  assign wr.ready   = i_rst_n && w_rdy;
  assign sram.we    = w_wr_go;
  assign sram.addr  = w_wr_go ? wr.addr : r_rd_addr;
  assign sram.wdata = w_wr_go ? wr.data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_inflight  <= 1'b0;
      r_pix       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd;
      if (i_frame_start) r_rd_addr <= '0;
      else if (w_rd)     r_rd_addr <= r_rd_addr + ADDR_W'(1);
      if (i_pix_req) r_pix <= w_empty ? '0 : w_head;
      if (i_frame_start)
        r_underflow <= 1'b0;
      else if (i_pix_req && w_empty)
        r_underflow <= 1'b1;
    end
  end

  assign o_pix       = r_pix;
  assign o_underflow = r_underflow;

endmodule
